// File: rtl/sr_config_loader_pkg.sv
// Shared constants and FSM encoding for the shift-register configuration loader.
package sr_config_loader_pkg;

  localparam int unsigned WIDTH  = 170;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned NWORDS = (WIDTH + WORD_W - 1) / WORD_W;

  typedef enum logic [1:0] {
    StCollect = 2'd0,
    StStart   = 2'd1,
    StWait    = 2'd2
  } state_e;

endpackage

// File: rtl/sr_word_packer.sv
// Packs a stream of host words into the staging register, lowest word first.
module sr_word_packer #(
  parameter int unsigned WIDTH  = sr_config_loader_pkg::WIDTH,
  parameter int unsigned WORD_W = sr_config_loader_pkg::WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [WORD_W-1:0] wr_data,
  output logic [WIDTH-1:0]  staging,
  output logic              last_word
);

  localparam int unsigned NW    = (WIDTH + WORD_W - 1) / WORD_W;
  localparam int unsigned IdxW  = (NW > 1) ? $clog2(NW) : 1;
  // The final word only carries the bits that remain above the full words.
  localparam int unsigned LastW = WIDTH - (NW - 1) * WORD_W;

  logic [IdxW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] staging_q, staging_d;

  assign last_word = (idx_q == IdxW'(NW - 1));
  assign staging   = staging_q;

  always_comb begin
    idx_d = idx_q;
    if (clear) begin
      idx_d = '0;
    end else if (wr_en) begin
      idx_d = last_word ? '0 : idx_q + IdxW'(1);
    end
  end

  always_comb begin
    staging_d = staging_q;
    if (wr_en) begin
      for (int i = 0; i < int'(NW) - 1; i++) begin
        if (idx_q == IdxW'(i)) begin
          staging_d[i*WORD_W +: WORD_W] = wr_data;
        end
      end
      if (last_word) begin
        staging_d[WIDTH-1 -: LastW] = wr_data[LastW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      staging_q <= '0;
    end else begin
      idx_q     <= idx_d;
      staging_q <= staging_d;
    end
  end

endmodule

// File: rtl/sr_config_loader.sv
// Loads a configuration word from host writes, pulses start, waits, then captures
// and compares the readback against the previously loaded configuration.
module sr_config_loader #(
  parameter int unsigned WIDTH  = sr_config_loader_pkg::WIDTH,
  parameter int unsigned WORD_W = sr_config_loader_pkg::WORD_W,
  parameter int unsigned WAIT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [WAIT_W-1:0] wait_cycles,
  output logic [WIDTH-1:0]  din,
  output logic              start,
  input  logic [WIDTH-1:0]  dout_in,
  output logic [WIDTH-1:0]  rb_data,
  output logic              done,
  output logic              busy,
  output logic              mismatch
);

  import sr_config_loader_pkg::*;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, w_q;
  logic              ready_en_q;
  logic [WIDTH-1:0]  rb_q, prev_cfg_q;
  logic              prev_valid_q, mismatch_q;
  logic [WIDTH-1:0]  staging;
  logic              last_word, accept, capture;

  assign accept  = wr_ready && wr_valid && !clear;
  assign capture = (state_q == StWait) && (cnt_q == w_q - WAIT_W'(1)) && !clear;

  sr_word_packer #(
    .WIDTH  (WIDTH),
    .WORD_W (WORD_W)
  ) u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .wr_en     (accept),
    .wr_data   (wr_data),
    .staging   (staging),
    .last_word (last_word)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StCollect: if (accept && last_word) state_d = StStart;
      StStart:   state_d = StWait;
      StWait:    if (capture) state_d = StCollect;
      default:   state_d = StCollect;
    endcase
    if (clear) state_d = StCollect;
  end

  // ready_en_q holds wr_ready low until the first edge after reset release.
  assign wr_ready = ready_en_q && (state_q == StCollect);
  assign busy     = (state_q != StCollect);
  assign start    = (state_q == StStart);
  assign done     = capture;
  assign din      = staging;
  assign rb_data  = rb_q;
  assign mismatch = mismatch_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StCollect;
      ready_en_q   <= 1'b0;
      cnt_q        <= '0;
      w_q          <= WAIT_W'(1);
      rb_q         <= '0;
      prev_cfg_q   <= '0;
      prev_valid_q <= 1'b0;
      mismatch_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
      if (state_q == StStart) begin
        cnt_q <= '0;
        w_q   <= (wait_cycles == '0) ? WAIT_W'(1) : wait_cycles;
      end else if (state_q == StWait) begin
        cnt_q <= cnt_q + WAIT_W'(1);
      end
      if (capture) begin
        rb_q         <= dout_in;
        mismatch_q   <= prev_valid_q && (dout_in != prev_cfg_q);
        prev_cfg_q   <= staging;
        prev_valid_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sr_config_loader.sv
// Directed bench for sr_config_loader: load sequences, latency, compare, clear and reset.
module tb_sr_config_loader;
  import sr_config_loader_pkg::*;

  localparam int unsigned WAIT_W = 16;
  typedef logic [WIDTH-1:0] wv_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clear = 1'b0;
  logic              wr_valid = 1'b0;
  logic [WORD_W-1:0] wr_data = '0;
  logic [WAIT_W-1:0] wait_cycles = '0;
  wv_t               dout_in = '0;
  logic              wr_ready, start, done, busy, mismatch;
  wv_t               din, rb_data;

  int n_total = 0;
  int n_bad   = 0;
  int acc_cnt = 0;
  int done_cnt = 0;
  int ready_busy_err = 0;

  logic [WORD_W-1:0] words [NWORDS];
  wv_t s1, s2, s5, tmp;
  int  acc_base, done_base;

  always #5 clk = ~clk;

  sr_config_loader #(
    .WIDTH  (WIDTH),
    .WORD_W (WORD_W),
    .WAIT_W (WAIT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wait_cycles (wait_cycles),
    .din         (din),
    .start       (start),
    .dout_in     (dout_in),
    .rb_data     (rb_data),
    .done        (done),
    .busy        (busy),
    .mismatch    (mismatch)
  );

  always @(posedge clk) begin
    if (wr_valid && wr_ready && !clear) acc_cnt <= acc_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  always @(negedge clk) begin
    if (busy && wr_ready) ready_busy_err <= ready_busy_err + 1;
  end

  task automatic check(input string tag, input wv_t got, input wv_t exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic wv_t pack_words();
    wv_t v;
    v = {words[5][9:0], words[4], words[3], words[2], words[1], words[0]};
    return v;
  endfunction

  task automatic send_words(input int n, input bit hold);
    int guard;
    for (int i = 0; i < n; i++) begin
      wr_data  = words[i];
      wr_valid = 1'b1;
      guard = 0;
      while (!wr_ready && guard < 50) begin
        tick();
        guard++;
      end
      if (guard == 50) check("send_ready", wv_t'(wr_ready), wv_t'(1));
      tick();
    end
    if (!hold) wr_valid = 1'b0;
  endtask

  // Leaves the bench one cycle after the done pulse, back in COLLECT.
  task automatic run_load(input string tag, input int wait_n, input int exp_lat,
                          input wv_t rb_in, input logic exp_mm, input bit hold);
    wv_t exp_s;
    int  lat;
    exp_s       = pack_words();
    wait_cycles = WAIT_W'(wait_n);
    dout_in     = rb_in;
    send_words(NWORDS, hold);
    check({tag, ".start"}, wv_t'(start), wv_t'(1));
    check({tag, ".busy"}, wv_t'(busy), wv_t'(1));
    check({tag, ".din"}, din, exp_s);
    lat = 0;
    do begin
      tick();
      lat++;
      if (lat == 1) check({tag, ".start_pulse"}, wv_t'(start), wv_t'(0));
    end while (!done && lat < exp_lat + 20);
    check({tag, ".latency"}, wv_t'(lat), wv_t'(exp_lat));
    check({tag, ".din_held"}, din, exp_s);
    tick();
    if (hold) wr_valid = 1'b0;
    check({tag, ".rb_data"}, rb_data, rb_in);
    check({tag, ".mismatch"}, wv_t'(mismatch), wv_t'(exp_mm));
    check({tag, ".idle"}, wv_t'({busy, done, wr_ready}), wv_t'(3'b001));
  endtask

  initial begin
    // Reset state
    #2;
    check("rst.din", din, '0);
    check("rst.rb", rb_data, '0);
    check("rst.ctl", wv_t'({start, done, busy, mismatch, wr_ready}), wv_t'(5'b0));
    tick();
    rst_n = 1'b1;
    tick();
    check("rst.ready_after", wv_t'(wr_ready), wv_t'(1));

    // First load: words 1..6, W=3, no previous config so no mismatch
    for (int i = 0; i < int'(NWORDS); i++) words[i] = WORD_W'(i + 1);
    s1 = pack_words();
    run_load("t1", 3, 3, s1, 1'b0, 1'b0);
    check("t1.din_lo", wv_t'(din[31:0]), wv_t'(32'd1));
    check("t1.din_hi", wv_t'(din[169:160]), wv_t'(10'h006));

    // All-ones load, readback equal to the first config
    for (int i = 0; i < int'(NWORDS); i++) words[i] = '1;
    s2 = '1;
    run_load("t2", 2, 2, s1, 1'b0, 1'b0);

    // Readback with bit 100 flipped against the all-ones config
    tmp = s2;
    tmp[100] = ~tmp[100];
    run_load("t3", 4, 4, tmp, 1'b1, 1'b0);
    repeat (5) tick();
    check("t3.mm_hold", wv_t'(mismatch), wv_t'(1));

    // wait_cycles=0 acts as W=1; matching readback clears mismatch
    run_load("t4", 0, 1, s2, 1'b0, 1'b0);

    // wr_valid held high through START/WAIT
    words[0] = 32'hA5A5_0000; words[1] = 32'hA5A5_0001; words[2] = 32'hA5A5_0002;
    words[3] = 32'hA5A5_0003; words[4] = 32'hA5A5_0004; words[5] = 32'hA5A5_0005;
    s5 = pack_words();
    acc_base = acc_cnt;
    run_load("t5", 3, 3, s2, 1'b0, 1'b1);
    check("t5.accepted", wv_t'(acc_cnt - acc_base), wv_t'(6));

    // Clear after three words; the word presented with clear is dropped
    words[0] = 32'h1111_0000; words[1] = 32'h1111_0001; words[2] = 32'h1111_0002;
    words[3] = 32'h1111_0003; words[4] = 32'h1111_0004; words[5] = 32'h1111_0005;
    send_words(3, 1'b0);
    clear    = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 32'hDEAD_BEEF;
    tick();
    clear    = 1'b0;
    wr_valid = 1'b0;
    check("t6.ready", wv_t'({busy, wr_ready}), wv_t'(2'b01));
    check("t6.w0", wv_t'(din[31:0]), wv_t'(32'h1111_0000));
    check("t6.w3_kept", wv_t'(din[127:96]), wv_t'(32'hA5A5_0003));
    check("t6.rb_kept", rb_data, s2);
    run_load("t6", 2, 2, s5, 1'b0, 1'b0);

    // Clear on the capture edge: no done, no capture
    wait_cycles = WAIT_W'(2);
    dout_in = '0;
    send_words(NWORDS, 1'b0);
    tick();
    tick();
    check("t7.done_pre", wv_t'(done), wv_t'(1));
    clear = 1'b1;
    #1;
    check("t7.done_clr", wv_t'(done), wv_t'(0));
    tick();
    clear = 1'b0;
    check("t7.rb_kept", rb_data, s5);
    check("t7.state", wv_t'({busy, done, mismatch}), wv_t'(3'b000));

    // Reset during WAIT
    for (int i = 0; i < int'(NWORDS); i++) words[i] = WORD_W'(32'hC0DE_0000 + i);
    wait_cycles = WAIT_W'(5);
    send_words(NWORDS, 1'b0);
    tick();
    tick();
    done_base = done_cnt;
    rst_n = 1'b0;
    #1;
    check("t8.din", din, '0);
    check("t8.rb", rb_data, '0);
    check("t8.ctl", wv_t'({start, done, busy, mismatch, wr_ready}), wv_t'(5'b0));
    tick();
    rst_n = 1'b1;
    repeat (8) tick();
    check("t8.no_done", wv_t'(done_cnt - done_base), wv_t'(0));
    tmp = '0;
    tmp[5] = 1'b1;
    run_load("t8", 2, 2, tmp, 1'b0, 1'b0);

    check("ready_while_busy", wv_t'(ready_busy_err), wv_t'(0));
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/sr_config_loader.md
SR_CONFIG_LOADER -- requirements
Module: sr_config_loader

Interface
REQ-001 The module SHALL have parameter WIDTH, default 170, giving the shift-register word width.
REQ-002 The module SHALL have parameter WORD_W, default 32, giving the host write-word width; NWORDS = ceil(WIDTH/WORD_W) = 6.
REQ-003 The module SHALL have parameter WAIT_W, default 16, giving the width of the wait-count input.
REQ-004 The module SHALL have port clk, input, 1 bit: the divided control clock, the same clock that drives the shift-register controller.
REQ-005 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The module SHALL have port clear, input, 1 bit: synchronous abort of a load in progress.
REQ-007 The module SHALL have ports wr_data (input, WORD_W), wr_valid (input, 1) and wr_ready (output, 1): the host word stream.
REQ-008 The module SHALL have port wait_cycles, input, WAIT_W: the number of clk cycles between start and readback capture.
REQ-009 The module SHALL have port din, output, WIDTH: the configuration word driven to the shift-register controller.
REQ-010 The module SHALL have port start, output, 1 bit: a one-cycle pulse to the controller and the receiver.
REQ-011 The module SHALL have port dout_in, input, WIDTH: the parallel readback from the receiver.
REQ-012 The module SHALL have ports rb_data (output, WIDTH), done (output, 1), busy (output, 1) and mismatch (output, 1).

Function
REQ-013 The FSM SHALL have the states COLLECT, START and WAIT.
REQ-014 In COLLECT, wr_ready SHALL be 1; each wr_valid&&wr_ready cycle SHALL write wr_data into staging slice [k*WORD_W +: WORD_W] for word index k = 0..5.
REQ-015 For word 5, only bits [9:0] SHALL be stored, into staging[169:160]; bits [31:10] SHALL be ignored.
REQ-016 Acceptance of word 5 SHALL reset k to 0 and move the FSM to START.
REQ-017 In START, start SHALL be 1 for exactly one cycle, the FSM SHALL latch W = max(wait_cycles,1), and it SHALL then enter WAIT.
REQ-018 din SHALL equal staging at all times, and staging SHALL NOT change outside COLLECT.
REQ-019 In WAIT, a counter cleared on entry SHALL increment each cycle.
REQ-020 On the edge where the WAIT counter equals W-1, the block SHALL update rb_data <= dout_in, pulse done for one cycle, and return to COLLECT.
REQ-021 Latency SHALL be: last word accepted at edge T, start high in cycle T+1, done and new rb_data visible in cycle T+1+W.
REQ-022 On the capture edge, mismatch SHALL be set to (prev_valid && dout_in != prev_cfg); prev_cfg SHALL be set to staging and prev_valid to 1.
REQ-023 mismatch SHALL hold its value until the next capture.
REQ-024 busy SHALL be 1 in START and WAIT, and 0 in COLLECT.
REQ-025 wr_ready SHALL be 0 whenever busy is 1; words presented while busy SHALL NOT be accepted.
REQ-026 clear SHALL force the FSM to COLLECT and k to 0, with start and done at 0 in the following cycle.
REQ-027 clear SHALL leave staging, rb_data, prev_cfg, prev_valid and mismatch unchanged.
REQ-028 When clear and wr_valid are asserted in the same cycle, clear SHALL win and the word SHALL NOT be accepted.
REQ-029 When clear is asserted on the capture edge, clear SHALL win: no capture, no done, no prev_cfg update.
REQ-030 The WAIT counter SHALL be WAIT_W bits wide; W = 2^WAIT_W - 1 SHALL be supported without wrap.

Reset
REQ-031 While rst_n = 0, the FSM SHALL be in COLLECT and k = 0.
REQ-032 While rst_n = 0, staging, din, rb_data and prev_cfg SHALL be 0.
REQ-033 While rst_n = 0, start, done, busy, mismatch and prev_valid SHALL be 0, and wr_ready SHALL be 1 from the first clk edge after release.
REQ-034 A reset asserted mid-load (any state) SHALL abandon the load with no done pulse.

Structure
REQ-035 A shared package SHALL hold the WIDTH, WORD_W and NWORDS constants and the FSM state encoding, for reuse by the top-level and the bench.
REQ-036 The word packer SHALL be one sub-module, sr_word_packer, containing the index counter and the staging register with its write enable; the FSM and readback comparison SHALL stay in sr_config_loader.

Verification
REQ-037 Reset then six words 0x00000001..0x00000006 with W=3 -> din[31:0]=1, din[169:160]=0x006, start high 1 cycle, done 3 cycles later, mismatch=0 (prev_valid was 0).
REQ-038 Second load of all-ones words with dout_in=first staging value -> mismatch=0; repeat with dout_in bit 100 flipped -> mismatch=1, and it stays 1 until the next capture.
REQ-039 wait_cycles=0 -> behaves as W=1: done exactly one cycle after start.
REQ-040 wr_valid held high continuously across START/WAIT -> exactly 6 words accepted per load, and wr_ready=0 while busy=1.
REQ-041 clear asserted after word 3 -> k=0, the next six words form a complete new load, and rb_data is unchanged.
REQ-042 rst_n pulsed low during WAIT -> all outputs 0 immediately, no done, and prev_valid=0 on the next load.
